// File: rtl/fetch_stage.sv
// fetch_stage: program-counter owner issuing in-order imem fetches into a prefetch queue with redirect flush
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  logic [31:0] fetch_pc, resp_pc, target;
  logic [31:0] q_instr [DEPTH];
  logic [31:0] q_pc [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, inflight, drop, inflight_nx;
  logic [CW:0] occ;
  logic issue, accept, deq;
  // every in-flight word already owns a queue slot, so the queue never overflows
  assign occ = {1'b0, count} + {1'b0, inflight};
  assign imem_req = rst & (occ < DEPTH_W);
  assign imem_addr = fetch_pc;
  assign issue = imem_req & imem_gnt;
  assign accept = imem_rvalid & (drop == '0);
  assign deq = out_valid & out_ready;
  assign inflight_nx = inflight + CW'(issue) - CW'(imem_rvalid);
  assign target = redirect_pc & ~32'h3;
  assign out_valid = count != '0;
  assign out_instr = q_instr[rd_ptr];
  assign out_pc = q_pc[rd_ptr];
  assign out_pc_plus4 = out_pc + 32'd4;
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      inflight <= '0;
      drop <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i] <= '0;
      end
    end else begin
      inflight <= inflight_nx;
      if (redirect) begin
        // anything still outstanding after this edge belongs to the old path
        fetch_pc <= target;
        resp_pc <= target;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
        drop <= inflight_nx;
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (imem_rvalid && drop != '0) drop <= drop - CW'(1);
        if (accept) begin
          q_instr[wr_ptr] <= imem_rdata;
          q_pc[wr_ptr] <= resp_pc;
          wr_ptr <= wr_ptr + AW'(1);
          resp_pc <= resp_pc + 32'd4;
        end
        if (deq) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(accept) - CW'(deq);
      end
    end
  end
endmodule
